// File: rtl/lynx_pkg.sv
// Shared types and decode constants for the Lynx memory controller.
// Holds the handshake state enum, I/O port decode patterns and read-mux select codes.
package lynx_pkg;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_REQ,
    HS_WAIT,
    HS_HOLD
  } hs_state_e;

  typedef enum logic [2:0] {
    SEL_FF,
    SEL_ROM,
    SEL_SDR,
    SEL_VB0,
    SEL_VB1,
    SEL_KB
  } rd_sel_e;

  // Write ports are partially decoded: 7F on a[6:0], 80/84 on a[7:6], a[2] and a[1].
  localparam logic [6:0] PORT_7F      = 7'h7F;
  localparam logic [7:0] PORT_8X_MASK = 8'hC6;
  localparam logic [7:0] PORT_80      = 8'h80;
  localparam logic [7:0] PORT_84      = 8'h84;
  localparam logic [7:0] PORT_KB      = 8'h80;

  function automatic rd_sel_e mem_sel(input logic [7:0] r7f, input logic [5:1] r80,
                                      input logic [2:0] a_hi, input logic rom15);
    if (!r7f[4] && a_hi[2:1] == 2'b00) return SEL_ROM;
    if (!r7f[4] && a_hi == 3'b010) return rom15 ? SEL_ROM : SEL_FF;
    if (!r7f[5]) return SEL_SDR;
    if (r7f[6] && !r80[2]) return SEL_VB0;
    if (r7f[6] && !r80[3]) return SEL_VB1;
    return SEL_FF;
  endfunction

endpackage

// File: rtl/lynx_sdr_hs.sv
// SDRAM request/acknowledge handshake with a timeout counter and read-data latch.
// state   | meaning
// IDLE    | no access; a start request stalls the CPU in the same cycle
// REQ     | one-cycle sdr_req pulse, counter cleared
// WAIT    | waiting for sdr_ack or counter timeout
// HOLD    | access finished, CPU released until mreq_n rises
module lynx_sdr_hs
  import lynx_pkg::*;
#(
  parameter int TMO_W = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic       we_i,
  input  logic       mreq_n_i,
  input  logic       sdr_ack_i,
  input  logic [7:0] sdr_do_i,
  output logic       sdr_req_o,
  output logic       sdr_we_o,
  output logic       wait_n_o,
  output logic [7:0] rdata_o,
  output logic       tmo_err_o
);

  hs_state_e        state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]       rdata_q, rdata_d;
  logic             tmo_q, tmo_d;
  logic             we_q, we_d;

  assign cnt_inc = cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HS_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      tmo_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    tmo_d     = tmo_q;
    we_d      = we_q;
    sdr_req_o = 1'b0;
    wait_n_o  = 1'b1;
    case (state_q)
      HS_IDLE: begin
        if (start_i) begin
          wait_n_o = 1'b0;
          we_d     = we_i;
          state_d  = HS_REQ;
        end
      end
      HS_REQ: begin
        sdr_req_o = 1'b1;
        wait_n_o  = 1'b0;
        cnt_d     = '0;
        state_d   = HS_WAIT;
      end
      HS_WAIT: begin
        wait_n_o = 1'b0;
        if (sdr_ack_i) begin
          if (!we_q) rdata_d = sdr_do_i;
          state_d = HS_HOLD;
        end else begin
          cnt_d = cnt_inc;
          // Give up on the cycle the counter lands on all-ones.
          if (cnt_inc == '1) begin
            tmo_d   = 1'b1;
            rdata_d = 8'hFF;
            state_d = HS_HOLD;
          end
        end
      end
      HS_HOLD: begin
        if (mreq_n_i) state_d = HS_IDLE;
      end
      default: state_d = HS_IDLE;
    endcase
  end

  assign sdr_we_o  = (state_q == HS_REQ) && we_q;
  assign rdata_o   = rdata_q;
  assign tmo_err_o = tmo_q;

endmodule

// File: rtl/lynx_mem_ctrl.sv
// Lynx memory controller: banking registers, CPU read mux, video bank writes
// and SDRAM routing through the handshake sub-module.
module lynx_mem_ctrl
  import lynx_pkg::*;
#(
  parameter int RAM_AW = 14,
  parameter int ROM_AW = 14,
  parameter int TMO_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [15:0]       a,
  input  logic [7:0]        q,
  output logic [7:0]        d,
  output logic              wait_n,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [7:0]        rom_do,
  output logic              sdr_req,
  output logic              sdr_we,
  output logic [23:0]       sdr_a,
  output logic [15:0]       sdr_di,
  input  logic [7:0]        sdr_do,
  input  logic              sdr_ack,
  output logic [1:0]        vb_we,
  output logic [13:0]       vb_a,
  output logic [7:0]        vb_di,
  input  logic [7:0]        vb_do0,
  input  logic [7:0]        vb_do1,
  input  logic [7:0]        kb_do,
  input  logic              ear,
  output logic              altg,
  output logic [5:0]        dac,
  output logic              tmo_err
);

  localparam logic ROM15 = (ROM_AW == 15);

  logic [7:0] r7f_q, r7f_d;
  logic [5:1] r80_q, r80_d;
  logic [5:0] dac_q, dac_d;
  logic       io_wr, wr7f, wr80, wr84;
  rd_sel_e    msel, rd_sel;
  logic       start;
  logic [7:0] sdr_rdata;

  assign io_wr = ce && !iorq_n && !wr_n;
  assign wr7f  = io_wr && (a[6:0] == PORT_7F);
  assign wr80  = io_wr && ((a[7:0] & PORT_8X_MASK) == PORT_80);
  assign wr84  = io_wr && ((a[7:0] & PORT_8X_MASK) == PORT_84);

  always_comb begin
    r7f_d = r7f_q;
    r80_d = r80_q;
    dac_d = dac_q;
    if (wr7f) r7f_d = q;
    if (wr80) r80_d = q[5:1];
    if (wr84) dac_d = q[5:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r7f_q <= '0;
      r80_q <= '0;
      dac_q <= '0;
    end else begin
      r7f_q <= r7f_d;
      r80_q <= r80_d;
      dac_q <= dac_d;
    end
  end

  // Routing uses the current register values, so a same-cycle port write
  // only affects accesses that start afterwards.
  assign msel  = mem_sel(r7f_q, r80_q, a[15:13], ROM15);
  assign start = ce && !mreq_n &&
                 ((!rd_n && msel == SEL_SDR) || (!wr_n && !r7f_q[0]));

  always_comb begin
    rd_sel = SEL_FF;
    if (!mreq_n) rd_sel = msel;
    else if (!iorq_n && a[7:0] == PORT_KB) rd_sel = SEL_KB;
  end

  always_comb begin
    d = 8'hFF;
    case (rd_sel)
      SEL_ROM: d = rom_do;
      SEL_SDR: d = sdr_rdata;
      SEL_VB0: d = vb_do0;
      SEL_VB1: d = vb_do1;
      SEL_KB:  d = {kb_do[7:1], r80_q[1] ? ear : kb_do[0]};
      default: d = 8'hFF;
    endcase
  end

  lynx_sdr_hs #(.TMO_W(TMO_W)) u_hs (
    .clock     (clock),
    .reset     (reset),
    .start_i   (start),
    .we_i      (!wr_n),
    .mreq_n_i  (mreq_n),
    .sdr_ack_i (sdr_ack),
    .sdr_do_i  (sdr_do),
    .sdr_req_o (sdr_req),
    .sdr_we_o  (sdr_we),
    .wait_n_o  (wait_n),
    .rdata_o   (sdr_rdata),
    .tmo_err_o (tmo_err)
  );

  assign rom_a  = a[ROM_AW-1:0];
  assign sdr_a  = (RAM_AW == 14) ? {10'h000, a[14], a[12:0]} : {8'h00, a};
  assign sdr_di = {q, q};

  assign vb_we[0] = !mreq_n && !wr_n && r7f_q[1] && r80_q[5];
  assign vb_we[1] = !mreq_n && !wr_n && r7f_q[2] && r80_q[5];
  assign vb_a     = {a[14], a[12:0]};
  assign vb_di    = q;

  assign altg = r80_q[4];
  assign dac  = dac_q;

endmodule

// File: tb/tb_lynx_mem_ctrl.sv
// Directed self-checking bench for lynx_mem_ctrl with default parameters.
module tb_lynx_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset, ce, mreq_n, iorq_n, rd_n, wr_n;
  logic [15:0] a;
  logic [7:0]  q, d;
  logic        wait_n;
  logic [13:0] rom_a;
  logic [7:0]  rom_do;
  logic        sdr_req, sdr_we;
  logic [23:0] sdr_a;
  logic [15:0] sdr_di;
  logic [7:0]  sdr_do;
  logic        sdr_ack;
  logic [1:0]  vb_we;
  logic [13:0] vb_a;
  logic [7:0]  vb_di, vb_do0, vb_do1, kb_do;
  logic        ear, altg;
  logic [5:0]  dac;
  logic        tmo_err;

  int checks = 0;
  int failures = 0;

  // Result slots filled by mem_cycle.
  int          r_low;
  logic        r_req, r_we, r_extra, r_exp;
  logic [23:0] r_a;
  logic [15:0] r_di;
  logic [7:0]  r_dfirst, r_dend;
  logic [1:0]  r_vbwe;
  logic [7:0]  io_d;

  always #5 clock = ~clock;

  assign rom_do = rom_a[7:0] ^ 8'hA5;
  assign vb_do0 = 8'h11;
  assign vb_do1 = 8'h22;

  lynx_mem_ctrl dut (
    .clock(clock), .reset(reset), .ce(ce), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .a(a), .q(q), .d(d), .wait_n(wait_n),
    .rom_a(rom_a), .rom_do(rom_do), .sdr_req(sdr_req), .sdr_we(sdr_we),
    .sdr_a(sdr_a), .sdr_di(sdr_di), .sdr_do(sdr_do), .sdr_ack(sdr_ack),
    .vb_we(vb_we), .vb_a(vb_a), .vb_di(vb_di), .vb_do0(vb_do0), .vb_do1(vb_do1),
    .kb_do(kb_do), .ear(ear), .altg(altg), .dac(dac), .tmo_err(tmo_err)
  );

  task automatic io_out(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clock);
    a = addr; q = data; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clock);
    iorq_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic io_in(input logic [15:0] addr, output logic [7:0] data);
    @(negedge clock);
    a = addr; iorq_n = 1'b0; rd_n = 1'b0;
    #1 data = d;
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  // One CPU memory access; ack_lat = edges from the sdr_req launch edge to the
  // edge that samples sdr_ack (0 = never acknowledge).
  task automatic mem_cycle(input logic wr, input logic [15:0] addr, input logic [7:0] data,
                           input int ack_lat);
    int req_k;
    r_low = 0; r_req = 0; r_we = 0; r_a = '0; r_di = '0; r_extra = 0; r_exp = 1; req_k = -100;
    @(negedge clock);
    a = addr; q = data; mreq_n = 1'b0;
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    #1 r_dfirst = d; r_vbwe = vb_we;
    for (int k = 0; k < 64; k++) begin
      if (sdr_req) begin
        r_req = 1; req_k = k; r_we = sdr_we; r_a = sdr_a; r_di = sdr_di;
      end
      if (wait_n) begin r_exp = 0; break; end
      r_low++;
      if (ack_lat > 0 && k == req_k + ack_lat - 1) sdr_ack = 1'b1;
      @(negedge clock);
      sdr_ack = 1'b0;
      #1;
    end
    r_dend = d;
    for (int j = 0; j < 2; j++) begin
      @(negedge clock); #1;
      if (sdr_req) r_extra = 1;
    end
    @(negedge clock);
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    @(negedge clock); #1;
    if (sdr_req) r_extra = 1;
    checks++;
    if (r_exp) begin failures++; $display("FAIL mem_cycle_bound addr=%h wait_n never released", addr); end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (wait_n !== 1'b1) begin failures++; $display("FAIL reset_wait_n got %b exp 1", wait_n); end
    checks++; if (sdr_req !== 1'b0) begin failures++; $display("FAIL reset_sdr_req got %b exp 0", sdr_req); end
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL reset_tmo_err got %b exp 0", tmo_err); end
    checks++; if ({altg, dac} !== 7'h00) begin failures++; $display("FAIL reset_altg_dac got %h exp 00", {altg, dac}); end
  endtask

  task automatic test_rom_map;
    mem_cycle(0, 16'h0010, 8'h00, 3);
    checks++; if (r_dend !== 8'hB5) begin failures++; $display("FAIL rom_0010_d got %h exp b5", r_dend); end
    checks++; if (r_low !== 0 || r_req !== 0 || r_extra !== 0) begin failures++; $display("FAIL rom_0010_nosdr got low=%0d req=%b exp 0 0", r_low, r_req); end
    mem_cycle(0, 16'h3FFF, 8'h00, 3);
    checks++; if (r_dend !== 8'h5A) begin failures++; $display("FAIL rom_3fff_d got %h exp 5a", r_dend); end
    mem_cycle(0, 16'h4000, 8'h00, 3);
    checks++; if (r_dend !== 8'hFF || r_req !== 0) begin failures++; $display("FAIL rom_4000_ff got d=%h req=%b exp ff 0", r_dend, r_req); end
    sdr_do = 8'h81;
    mem_cycle(0, 16'h8000, 8'h00, 3);
    checks++; if (r_dend !== 8'h81 || r_req !== 1) begin failures++; $display("FAIL sdr_8000_read got d=%h req=%b exp 81 1", r_dend, r_req); end
  endtask

  task automatic test_sdram_read;
    io_out(16'h007F, 8'h10);
    sdr_do = 8'h5A;
    mem_cycle(0, 16'h0010, 8'h00, 3);
    checks++; if (r_low !== 4) begin failures++; $display("FAIL sdr_read_wait_cycles got %0d exp 4", r_low); end
    checks++; if (r_dend !== 8'h5A) begin failures++; $display("FAIL sdr_read_d got %h exp 5a", r_dend); end
    checks++; if (r_req !== 1 || r_we !== 0) begin failures++; $display("FAIL sdr_read_req got req=%b we=%b exp 1 0", r_req, r_we); end
    checks++; if (r_extra !== 0) begin failures++; $display("FAIL sdr_hold_no_new_req got %b exp 0", r_extra); end
  endtask

  task automatic test_stray_ack;
    @(negedge clock);
    sdr_do = 8'h77; sdr_ack = 1'b1;
    @(negedge clock);
    sdr_ack = 1'b0; sdr_do = 8'h3C;
    mem_cycle(0, 16'h0010, 8'h00, 3);
    checks++; if (r_dfirst !== 8'h5A) begin failures++; $display("FAIL stray_ack_latch got %h exp 5a", r_dfirst); end
    checks++; if (r_dend !== 8'h3C) begin failures++; $display("FAIL stray_ack_next_read got %h exp 3c", r_dend); end
  endtask

  task automatic test_sdram_write;
    mem_cycle(1, 16'h6ABC, 8'h33, 3);
    checks++; if (r_a !== 24'h002ABC) begin failures++; $display("FAIL sdr_write_addr got %h exp 002abc", r_a); end
    checks++; if (r_di !== 16'h3333 || r_we !== 1) begin failures++; $display("FAIL sdr_write_data got di=%h we=%b exp 3333 1", r_di, r_we); end
    checks++; if (r_low !== 4) begin failures++; $display("FAIL sdr_write_wait_cycles got %0d exp 4", r_low); end
  endtask

  task automatic test_video;
    io_out(16'h007F, 8'h02);
    io_out(16'h0080, 8'h20);
    mem_cycle(1, 16'hC000, 8'h44, 3);
    checks++; if (r_vbwe !== 2'b01) begin failures++; $display("FAIL vb_we_red got %b exp 01", r_vbwe); end
    io_out(16'h007F, 8'h04);
    mem_cycle(1, 16'hC000, 8'h44, 3);
    checks++; if (r_vbwe !== 2'b10) begin failures++; $display("FAIL vb_we_green got %b exp 10", r_vbwe); end
    io_out(16'h007F, 8'h01);
    mem_cycle(1, 16'hC000, 8'h44, 3);
    checks++; if (r_vbwe !== 2'b00 || r_req !== 0 || r_low !== 0) begin failures++; $display("FAIL vb_we_off got vbwe=%b req=%b low=%0d exp 00 0 0", r_vbwe, r_req, r_low); end
    io_out(16'h007F, 8'h60);
    io_out(16'h0080, 8'h00);
    mem_cycle(0, 16'h8000, 8'h00, 3);
    checks++; if (r_dend !== 8'h11 || r_req !== 0) begin failures++; $display("FAIL vb_read0 got d=%h req=%b exp 11 0", r_dend, r_req); end
    io_out(16'h0080, 8'h04);
    mem_cycle(0, 16'h8000, 8'h00, 3);
    checks++; if (r_dend !== 8'h22) begin failures++; $display("FAIL vb_read1 got %h exp 22", r_dend); end
    io_out(16'h0080, 8'h0C);
    mem_cycle(0, 16'h8000, 8'h00, 3);
    checks++; if (r_dend !== 8'hFF) begin failures++; $display("FAIL vb_read_none got %h exp ff", r_dend); end
  endtask

  task automatic test_io_ports;
    io_out(16'h0080, 8'h02);
    ear = 1'b0; kb_do = 8'hFF;
    io_in(16'h0080, io_d);
    checks++; if (io_d !== 8'hFE) begin failures++; $display("FAIL kb_ear0 got %h exp fe", io_d); end
    ear = 1'b1;
    io_in(16'h0080, io_d);
    checks++; if (io_d !== 8'hFF) begin failures++; $display("FAIL kb_ear1 got %h exp ff", io_d); end
    io_out(16'h0080, 8'h00);
    kb_do = 8'h5A;
    io_in(16'h0080, io_d);
    checks++; if (io_d !== 8'h5A) begin failures++; $display("FAIL kb_plain got %h exp 5a", io_d); end
    io_in(16'h0081, io_d);
    checks++; if (io_d !== 8'hFF) begin failures++; $display("FAIL io_unmatched got %h exp ff", io_d); end
    io_out(16'h0080, 8'h10);
    io_out(16'h0084, 8'hEA);
    #1;
    checks++; if (altg !== 1'b1 || dac !== 6'h2A) begin failures++; $display("FAIL altg_dac got altg=%b dac=%h exp 1 2a", altg, dac); end
  endtask

  task automatic test_timeout;
    io_out(16'h007F, 8'h10);
    #1;
    checks++; if (tmo_err !== 1'b0) begin failures++; $display("FAIL tmo_before got %b exp 0", tmo_err); end
    mem_cycle(0, 16'h0100, 8'h00, 0);
    checks++; if (r_low !== 17) begin failures++; $display("FAIL tmo_wait_cycles got %0d exp 17", r_low); end
    checks++; if (tmo_err !== 1'b1 || r_dend !== 8'hFF) begin failures++; $display("FAIL tmo_result got err=%b d=%h exp 1 ff", tmo_err, r_dend); end
  endtask

  task automatic test_reset_mid_wait;
    logic found;
    found = 0;
    @(negedge clock);
    a = 16'h8000; mreq_n = 1'b0; rd_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (sdr_req) begin found = 1; break; end
      @(negedge clock);
    end
    checks++; if (!found) begin failures++; $display("FAIL midwait_req got 0 exp 1"); end
    @(negedge clock);
    reset = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if (wait_n !== 1'b1 || sdr_req !== 1'b0) begin failures++; $display("FAIL midwait_reset got wait_n=%b req=%b exp 1 0", wait_n, sdr_req); end
    checks++; if (tmo_err !== 1'b0 || altg !== 1'b0) begin failures++; $display("FAIL midwait_clear got tmo=%b altg=%b exp 0 0", tmo_err, altg); end
    sdr_do = 8'h99; sdr_ack = 1'b1;
    @(negedge clock);
    sdr_ack = 1'b0;
    #1;
    checks++; if (wait_n !== 1'b1 || tmo_err !== 1'b0) begin failures++; $display("FAIL late_ack got wait_n=%b tmo=%b exp 1 0", wait_n, tmo_err); end
    mem_cycle(0, 16'h0010, 8'h00, 3);
    checks++; if (r_dend !== 8'hB5 || r_req !== 0) begin failures++; $display("FAIL post_reset_rom got d=%h req=%b exp b5 0", r_dend, r_req); end
    io_out(16'h007F, 8'h10);
    sdr_do = 8'hC7;
    mem_cycle(0, 16'h0010, 8'h00, 3);
    checks++; if (r_dfirst !== 8'h00 || r_dend !== 8'hC7 || r_low !== 4) begin failures++; $display("FAIL post_reset_sdr got first=%h end=%h low=%0d exp 00 c7 4", r_dfirst, r_dend, r_low); end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a = '0; q = '0; sdr_do = '0; sdr_ack = 1'b0; kb_do = 8'hFF; ear = 1'b0;
    test_reset;
    test_rom_map;
    test_sdram_read;
    test_stray_ack;
    test_sdram_write;
    test_video;
    test_io_ports;
    test_timeout;
    test_reset_mid_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lynx_mem_ctrl.md
LYNX_MEM_CTRL -- requirements
Module: lynx_mem_ctrl

Interface
REQ-001 Parameter RAM_AW, default 14, CPU RAM address width; 14 = 48K map, 16 = 96K map.
REQ-002 Parameter ROM_AW, default 14, ROM address width; 14 or 15.
REQ-003 Parameter TMO_W, default 4, width of the SDRAM acknowledge timeout counter.
REQ-004 Ports: clock in 1 system clock; reset in 1 synchronous active-high reset; ce in 1 CPU clock enable.
REQ-005 Ports: mreq_n, iorq_n, rd_n, wr_n in 1 each, CPU strobes; a in 16 address; q in 8 CPU write data.
REQ-006 Ports: d out 8 read data to CPU; wait_n out 1 CPU wait request.
REQ-007 Ports: rom_a out ROM_AW ROM address; rom_do in 8 ROM data.
REQ-008 Ports: sdr_req out 1; sdr_we out 1; sdr_a out 24; sdr_di out 16; sdr_do in 8; sdr_ack in 1 one-cycle completion pulse.
REQ-009 Ports: vb_we out 2 video bank write enables (bit0 red/blue, bit1 green); vb_a out 14; vb_di out 8; vb_do0, vb_do1 in 8 each.
REQ-010 Ports: kb_do in 8 keyboard column data; ear in 1; altg out 1; dac out 6; tmo_err out 1 sticky timeout flag.

Function
REQ-011 Write with !iorq_n, !wr_n, a[6:0]=7F on ce SHALL load reg7F from q.
REQ-012 Write with a[7]=1, a[6]=0, a[2]=0, a[1]=0 SHALL load reg80[5:1] from q[5:1]; altg = reg80[4].
REQ-013 Write with a[7]=1, a[6]=0, a[2]=1, a[1]=0 SHALL load dac from q[5:0].
REQ-014 Read mux priority (mreq_n low): reg7F[4]=0 and a[15:14]=00 -> rom_do; reg7F[4]=0 and a[15:13]=010 -> rom_do if ROM_AW=15 else FF; reg7F[5]=0 -> latched SDRAM data; reg7F[6]=1 and reg80[2]=0 -> vb_do0; reg7F[6]=1 and reg80[3]=0 -> vb_do1; else FF.
REQ-015 Read with iorq_n low and a[7:0]=80 SHALL return {kb_do[7:1], reg80[1] ? ear : kb_do[0]}; other unmatched reads return FF.
REQ-016 sdr_a = {8'h00, a[14], a[12:0]} zero-extended when RAM_AW=14, else {8'h00, a}; sdr_di = {q, q}.
REQ-017 vb_we[0] = !mreq_n and !wr_n and reg7F[1] and reg80[5]; vb_we[1] likewise with reg7F[2]; vb_a = {a[14], a[12:0]}; vb_di = q.
REQ-018 SDRAM FSM states IDLE, REQ, WAIT, HOLD.
REQ-019 IDLE->REQ on ce with mreq_n low and either a read selecting SDRAM (REQ-014) or a write with reg7F[0]=0; wait_n driven low same cycle.
REQ-020 REQ: sdr_req high exactly one cycle, sdr_we = write; -> WAIT; timeout counter cleared.
REQ-021 WAIT: on sdr_ack latch sdr_do (reads) -> HOLD, wait_n high next cycle; each cycle without ack increments the counter.
REQ-022 Counter reaching all-ones in WAIT SHALL set tmo_err, latch FF as read data, -> HOLD.
REQ-023 HOLD -> IDLE when mreq_n high; no new request while in HOLD.
REQ-024 sdr_ack outside WAIT SHALL be ignored.
REQ-025 Register write and SDRAM request in the same cycle SHALL both take effect; SDRAM routing uses pre-write register values.

Reset
REQ-026 reset SHALL clear reg7F, reg80, dac, tmo_err, latched data and counter, force FSM to IDLE, sdr_req low, wait_n high, next clock edge.
REQ-027 reset during REQ/WAIT/HOLD SHALL abandon the access; a late sdr_ack is ignored.
REQ-028 After reset: ROM mapped at 0000-3FFF, SDRAM read/write enabled, video bank writes disabled.

Structure
REQ-029 FSM state enum, port decode constants (7F, 80, 84 masks) and read-mux select codes SHALL live in shared package lynx_pkg.
REQ-030 The SDRAM handshake FSM with timeout counter SHALL be the single sub-module lynx_sdr_hs.

Verification
REQ-031 Reset, read 0x0010 -> d = rom_do, wait_n high, sdr_req never asserted.
REQ-032 OUT 7F,0x10; read 0x0010 with sdr_ack 3 cycles after sdr_req, sdr_do=5A -> wait_n low 4 cycles, d=5A.
REQ-033 RAM_AW=14, write 0x6ABC data 33 -> sdr_a=0x002ABC, sdr_di=3333, sdr_we=1.
REQ-034 TMO_W=4, read SDRAM, no ack -> after 15 WAIT cycles tmo_err=1, d=FF, wait_n released.
REQ-035 OUT 7F,0x02; OUT 80,0x20; write 0xC000 -> vb_we=01; same with OUT 7F,0x01 -> vb_we=00, no SDRAM write.
REQ-036 OUT 80,0x02, ear=0, kb_do=FF, IN 80 -> d=FE; reset asserted mid-WAIT -> FSM IDLE, wait_n high next cycle.
